instr_decoder: RTL and testbench
================================

Name: instr_decoder

Overview:
- Registered ARM-style 32-bit instruction decoder for the decode stage of the ARM32 CPU pipeline.
- Splits a fetched word into condition, internal 7-bit opcode, status-enable, register indices, shift/immediate fields and P/U/W addressing bits.
- All outputs are captured into registers on the clock edge, so they feed the next pipeline stage with 1-cycle latency.

Parameters:
- None.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous and active-high.
- instr  input  32  instruction word.
- cond  output  4  condition field.
- opcode  output  7  internal opcode (encoding in Behaviour).
- en_status  output  1  update status flags.
- rn  output  4  first operand register.
- rd  output  4  destination register.
- rs  output  4  shift-amount register.
- rm  output  4  second operand register.
- shift_op  output  2  shift type.
- imm5  output  5  immediate shift amount.
- imm12  output  12  12-bit immediate.
- imm24  output  24  branch offset.
- P  output  1  pre-index bit.
- U  output  1  add-offset bit.
- W  output  1  writeback bit.

Behaviour:
- Reset (async, rst=1): every output register clears to 0; opcode 0000000 is NOP. Once rst deasserts, outputs update on the next rising clk edge.
- Latency: on each rising clk, outputs take the decode of the instr value present at that edge. There is no enable; decode runs every cycle.
- Raw field extraction, unconditional for every instruction:
  - cond=instr[31:28], rn=[19:16], rd=[15:12], rs=[11:8], rm=[3:0]
  - shift_op=[6:5], imm5=[11:7], imm12=[11:0], imm24=[23:0]
  - P=[24], U=[23], W=[21]
- Opcode decode, first match wins:
  1. instr[27:0]==28'h1000000 -> HALT 0000001.
  2. instr[27:16]==12'h320 -> NOP 0000000.
  3. Data processing (instr[27:26]==00): opcode = {0, class[1:0], dp[3:0]}.
     - class: instr[25]=1 -> 00 (immediate); instr[25]=0 and instr[4]=0 -> 01 (register); instr[25]=0, instr[4]=1, instr[7]=0 -> 11 (register-shifted register).
     - instr[25]=0, instr[4]=1, instr[7]=1 -> NOP (unsupported).
     - Class 10 is reserved.
     - dp from ARM op instr[24:21]: AND 0000, EOR 0001, TST 0010, TEQ 0011, ORR 0100, MOV 0101, BIC 0110, MVN 0111, ADD 1000, ADC 1001, CMP 1010, CMN 1011, SUB 1100, SBC 1101, RSB 1110, RSC 1111.
     - The dp field is the translated internal code (e.g. ADD 0100 -> 1000), not the raw ARM op bits.
  4. Load/store (instr[27:26]==01); the byte bit instr[22] is ignored (word access only).
     - instr[25]=1 and instr[4]=1 -> NOP.
     - LDR literal (instr[20]=1, instr[25]=0, rn==1111) -> {1001, P, U, W}.
     - Otherwise -> {11, ~instr[20], ~instr[25], P, U, W}.
  5. Branch (instr[27:25]==101) -> {100000, instr[24]}: B = 1000000, BL = 1000001.
  6. Anything else -> NOP.
- en_status = instr[20] for data-processing opcodes, 0 for every other opcode (including HALT/NOP).
- Raw fields are never masked, even for NOP/HALT/undefined instructions.

Test Plan:
- Full field check: assert rst, then release; apply 0x51555555 and clock once. Required: cond 0101, opcode 0111010 (CMP reg-shift), en_status 1, rn/rd/rs/rm all 0101, shift_op 10, imm5 01010, imm12 0x555, imm24 0x555555, P 1, U 0, W 0.
- Special words, one clock each:
  - 0x03200000 -> opcode 0000000.
  - 0x01000000 -> 0000001, en_status 0.
- ADD forms, one clock each:
  - 0x029F7E50 -> 0001000.
  - 0x009F7E38 -> 0111000.
  - 0x009F7E28 -> 0011000.
- Load/store, one clock each:
  - 0xE5BF0000 -> 1001111 (LDR literal).
  - 0xE5310000 -> 1101101 (LDR immediate).
  - 0xE6910000 -> 1100010 (LDR register).
  - 0xE50A0000 -> 1111100 (STR immediate).
  - 0xE6AA0000 -> 1110011 (STR register).
- Branch: 0x8AC5AACC -> opcode 1000000, imm24 0xC5AACC; 0xEB000010 -> 1000001.
- Reset: load a decoded value, assert rst between clock edges -> every output 0 immediately, without waiting for a clock edge; after release, the next edge loads the decode again.

Source files
------------

// File: rtl/instr_decoder.sv
// Decode stage for ARM32-style instructions: raw fields are captured every cycle and
// the internal 7-bit opcode is generated. All outputs are registered with 1-cycle latency.
module instr_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic [3:0]  cond,
    output logic [6:0]  opcode,
    output logic        en_status,
    output logic [3:0]  rn,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  rm,
    output logic [1:0]  shift_op,
    output logic [4:0]  imm5,
    output logic [11:0] imm12,
    output logic [23:0] imm24,
    output logic        P,
    output logic        U,
    output logic        W
);

    localparam int unsigned OPC_W = 7;
    localparam int unsigned DP_W  = 4;

    localparam logic [OPC_W-1:0] OPC_NOP  = 7'b000_0000;
    localparam logic [OPC_W-1:0] OPC_HALT = 7'b000_0001;

    localparam logic [1:0] CLS_IMM = 2'b00;
    localparam logic [1:0] CLS_REG = 2'b01;
    localparam logic [1:0] CLS_RSR = 2'b11;

    logic [OPC_W-1:0] opcode_d, opcode_q;
    logic             en_status_d, en_status_q;
    logic [DP_W-1:0]  dp_code;

    logic [3:0]  cond_q, rn_q, rd_q, rs_q, rm_q;
    logic [1:0]  shift_op_q;
    logic [4:0]  imm5_q;
    logic [11:0] imm12_q;
    logic [23:0] imm24_q;
    logic        p_q, u_q, w_q;

    logic bit_i, bit_p, bit_u, bit_w, bit_l, bit_4, bit_7;

    assign bit_i = instr[25];
    assign bit_p = instr[24];
    assign bit_u = instr[23];
    assign bit_w = instr[21];
    assign bit_l = instr[20];
    assign bit_4 = instr[4];
    assign bit_7 = instr[7];

    // ARM data-processing op field translated to the internal ALU code
    always_comb begin
        dp_code = 4'b0000;
        unique case (instr[24:21])
            4'b0000: dp_code = 4'b0000; // AND
            4'b0001: dp_code = 4'b0001; // EOR
            4'b0010: dp_code = 4'b1100; // SUB
            4'b0011: dp_code = 4'b1110; // RSB
            4'b0100: dp_code = 4'b1000; // ADD
            4'b0101: dp_code = 4'b1001; // ADC
            4'b0110: dp_code = 4'b1101; // SBC
            4'b0111: dp_code = 4'b1111; // RSC
            4'b1000: dp_code = 4'b0010; // TST
            4'b1001: dp_code = 4'b0011; // TEQ
            4'b1010: dp_code = 4'b1010; // CMP
            4'b1011: dp_code = 4'b1011; // CMN
            4'b1100: dp_code = 4'b0100; // ORR
            4'b1101: dp_code = 4'b0101; // MOV
            4'b1110: dp_code = 4'b0110; // BIC
            4'b1111: dp_code = 4'b0111; // MVN
            default: dp_code = 4'b0000;
        endcase
    end

    // Opcode selection in priority order; status update only for data processing
    always_comb begin
        opcode_d    = OPC_NOP;
        en_status_d = 1'b0;
        if (instr[27:0] == 28'h100_0000) begin
            opcode_d = OPC_HALT;
        end else if (instr[27:16] == 12'h320) begin
            opcode_d = OPC_NOP;
        end else if (instr[27:26] == 2'b00) begin
            if (bit_i) begin
                opcode_d    = {1'b0, CLS_IMM, dp_code};
                en_status_d = bit_l;
            end else if (!bit_4) begin
                opcode_d    = {1'b0, CLS_REG, dp_code};
                en_status_d = bit_l;
            end else if (!bit_7) begin
                opcode_d    = {1'b0, CLS_RSR, dp_code};
                en_status_d = bit_l;
            end else begin
                opcode_d = OPC_NOP;
            end
        end else if (instr[27:26] == 2'b01) begin
            if (bit_i && bit_4) begin
                opcode_d = OPC_NOP;
            end else if (bit_l && !bit_i && (instr[19:16] == 4'hF)) begin
                opcode_d = {4'b1001, bit_p, bit_u, bit_w};
            end else begin
                opcode_d = {2'b11, ~bit_l, ~bit_i, bit_p, bit_u, bit_w};
            end
        end else if (instr[27:25] == 3'b101) begin
            opcode_d = {6'b100000, bit_p};
        end
    end

    // Pipeline register; raw fields pass through unmasked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_q      <= '0;
            opcode_q    <= '0;
            en_status_q <= 1'b0;
            rn_q        <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            rm_q        <= '0;
            shift_op_q  <= '0;
            imm5_q      <= '0;
            imm12_q     <= '0;
            imm24_q     <= '0;
            p_q         <= 1'b0;
            u_q         <= 1'b0;
            w_q         <= 1'b0;
        end else begin
            cond_q      <= instr[31:28];
            opcode_q    <= opcode_d;
            en_status_q <= en_status_d;
            rn_q        <= instr[19:16];
            rd_q        <= instr[15:12];
            rs_q        <= instr[11:8];
            rm_q        <= instr[3:0];
            shift_op_q  <= instr[6:5];
            imm5_q      <= instr[11:7];
            imm12_q     <= instr[11:0];
            imm24_q     <= instr[23:0];
            p_q         <= bit_p;
            u_q         <= bit_u;
            w_q         <= bit_w;
        end
    end

    assign cond      = cond_q;
    assign opcode    = opcode_q;
    assign en_status = en_status_q;
    assign rn        = rn_q;
    assign rd        = rd_q;
    assign rs        = rs_q;
    assign rm        = rm_q;
    assign shift_op  = shift_op_q;
    assign imm5      = imm5_q;
    assign imm12     = imm12_q;
    assign imm24     = imm24_q;
    assign P         = p_q;
    assign U         = u_q;
    assign W         = w_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder: hand-decoded instruction words checked one clock after
// being applied, plus asynchronous reset behaviour.
module tb_instr_decoder;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [3:0]  cond;
    logic [6:0]  opcode;
    logic        en_status;
    logic [3:0]  rn, rd, rs, rm;
    logic [1:0]  shift_op;
    logic [4:0]  imm5;
    logic [11:0] imm12;
    logic [23:0] imm24;
    logic        P, U, W;

    int checks = 0;
    int errors = 0;

    instr_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .cond      (cond),
        .opcode    (opcode),
        .en_status (en_status),
        .rn        (rn),
        .rd        (rd),
        .rs        (rs),
        .rm        (rm),
        .shift_op  (shift_op),
        .imm5      (imm5),
        .imm12     (imm12),
        .imm24     (imm24),
        .P         (P),
        .U         (U),
        .W         (W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // All outputs concatenated, 74 bits
    function automatic logic [73:0] all_outs();
        return {cond, opcode, en_status, rn, rd, rs, rm, shift_op, imm5, imm12, imm24, P, U, W};
    endfunction

    // Apply a word at the falling edge, then sample 1 time unit after the rising edge
    task automatic step(input logic [31:0] w);
        @(negedge clk);
        instr = w;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        instr = 32'h5155_5555;
        @(posedge clk);
        #1;
        checks++;
        if (all_outs() !== 74'd0) begin
            errors++;
            $display("FAIL reset_hold: got %h required 0", all_outs());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_fields();
        step(32'h5155_5555);
        checks++; if (cond !== 4'b0101) begin errors++; $display("FAIL ff_cond: got %b required 0101", cond); end
        checks++; if (opcode !== 7'b0111010) begin errors++; $display("FAIL ff_opcode: got %b required 0111010", opcode); end
        checks++; if (en_status !== 1'b1) begin errors++; $display("FAIL ff_en_status: got %b required 1", en_status); end
        checks++; if (rn !== 4'b0101) begin errors++; $display("FAIL ff_rn: got %b required 0101", rn); end
        checks++; if (rd !== 4'b0101) begin errors++; $display("FAIL ff_rd: got %b required 0101", rd); end
        checks++; if (rs !== 4'b0101) begin errors++; $display("FAIL ff_rs: got %b required 0101", rs); end
        checks++; if (rm !== 4'b0101) begin errors++; $display("FAIL ff_rm: got %b required 0101", rm); end
        checks++; if (shift_op !== 2'b10) begin errors++; $display("FAIL ff_shift_op: got %b required 10", shift_op); end
        checks++; if (imm5 !== 5'b01010) begin errors++; $display("FAIL ff_imm5: got %b required 01010", imm5); end
        checks++; if (imm12 !== 12'h555) begin errors++; $display("FAIL ff_imm12: got %h required 555", imm12); end
        checks++; if (imm24 !== 24'h555555) begin errors++; $display("FAIL ff_imm24: got %h required 555555", imm24); end
        checks++; if ({P, U, W} !== 3'b100) begin errors++; $display("FAIL ff_puw: got %b required 100", {P, U, W}); end
    endtask

    task automatic test_special();
        step(32'h0320_0000);
        checks++; if (opcode !== 7'b0000000) begin errors++; $display("FAIL sp_nop: got %b required 0000000", opcode); end
        step(32'h0100_0000);
        checks++; if ({opcode, en_status} !== 8'b0000001_0) begin errors++; $display("FAIL sp_halt: got %b required 00000010", {opcode, en_status}); end
        // NOP hint still passes raw fields through
        step(32'hF320_ABCD);
        checks++; if ({cond, opcode, rd, imm12} !== {4'hF, 7'b0000000, 4'hA, 12'hBCD}) begin
            errors++; $display("FAIL sp_nop_raw: got %h required %h", {cond, opcode, rd, imm12}, {4'hF, 7'b0000000, 4'hA, 12'hBCD});
        end
    endtask

    task automatic test_dp();
        step(32'h029F_7E50);
        checks++; if ({opcode, en_status} !== 8'b0001000_1) begin errors++; $display("FAIL dp_add_imm: got %b required 00010001", {opcode, en_status}); end
        step(32'h009F_7E38);
        checks++; if (opcode !== 7'b0111000) begin errors++; $display("FAIL dp_add_rsr: got %b required 0111000", opcode); end
        step(32'h009F_7E28);
        checks++; if (opcode !== 7'b0011000) begin errors++; $display("FAIL dp_add_reg: got %b required 0011000", opcode); end
        step(32'h01A0_0001);
        checks++; if ({opcode, en_status} !== 8'b0010101_0) begin errors++; $display("FAIL dp_mov_reg: got %b required 00101010", {opcode, en_status}); end
        step(32'h0050_0002);
        checks++; if ({opcode, en_status} !== 8'b0011100_1) begin errors++; $display("FAIL dp_subs_reg: got %b required 00111001", {opcode, en_status}); end
        step(32'h0011_0090);
        checks++; if ({opcode, en_status} !== 8'b0000000_0) begin errors++; $display("FAIL dp_unsupported: got %b required 00000000", {opcode, en_status}); end
    endtask

    task automatic test_load_store();
        step(32'hE5BF_0000);
        checks++; if ({opcode, en_status} !== 8'b1001111_0) begin errors++; $display("FAIL ls_ldr_lit: got %b required 10011110", {opcode, en_status}); end
        step(32'hE531_0000);
        checks++; if (opcode !== 7'b1101101) begin errors++; $display("FAIL ls_ldr_imm: got %b required 1101101", opcode); end
        step(32'hE691_0000);
        checks++; if (opcode !== 7'b1100010) begin errors++; $display("FAIL ls_ldr_reg: got %b required 1100010", opcode); end
        step(32'hE50A_0000);
        checks++; if (opcode !== 7'b1111100) begin errors++; $display("FAIL ls_str_imm: got %b required 1111100", opcode); end
        step(32'hE6AA_0000);
        checks++; if (opcode !== 7'b1110011) begin errors++; $display("FAIL ls_str_reg: got %b required 1110011", opcode); end
        step(32'h0610_0010);
        checks++; if (opcode !== 7'b0000000) begin errors++; $display("FAIL ls_reg_bit4: got %b required 0000000", opcode); end
        step(32'h0C00_0000);
        checks++; if (opcode !== 7'b0000000) begin errors++; $display("FAIL undefined: got %b required 0000000", opcode); end
    endtask

    task automatic test_branch();
        step(32'h8AC5_AACC);
        checks++; if ({cond, opcode, imm24} !== {4'h8, 7'b1000000, 24'hC5AACC}) begin
            errors++; $display("FAIL br_b: got %h required %h", {cond, opcode, imm24}, {4'h8, 7'b1000000, 24'hC5AACC});
        end
        step(32'hEB00_0010);
        checks++; if ({opcode, en_status} !== 8'b1000001_0) begin errors++; $display("FAIL br_bl: got %b required 10000010", {opcode, en_status}); end
    endtask

    task automatic test_back_to_back();
        // Output after each edge must reflect only the word present at that edge
        step(32'h029F_7E50);
        step(32'hEB00_0010);
        checks++; if ({opcode, imm24} !== {7'b1000001, 24'h000010}) begin errors++; $display("FAIL b2b_second: got %h required %h", {opcode, imm24}, {7'b1000001, 24'h000010}); end
        step(32'hE5BF_0000);
        checks++; if ({opcode, rn} !== {7'b1001111, 4'hF}) begin errors++; $display("FAIL b2b_third: got %h required %h", {opcode, rn}, {7'b1001111, 4'hF}); end
    endtask

    task automatic test_async_reset();
        step(32'h5155_5555);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs() !== 74'd0) begin errors++; $display("FAIL async_reset: got %h required 0", all_outs()); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({cond, opcode, en_status, imm24} !== {4'h5, 7'b0111010, 1'b1, 24'h555555}) begin
            errors++; $display("FAIL reset_reload: got %h required %h", {cond, opcode, en_status, imm24}, {4'h5, 7'b0111010, 1'b1, 24'h555555});
        end
    endtask

    initial begin
        rst   = 1'b1;
        instr = 32'h0;
        test_reset();
        test_full_fields();
        test_special();
        test_dp();
        test_load_store();
        test_branch();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
